controlador_estados: RTL and testbench
======================================

# controlador_estados

Central state sequencer for the pet: it arbitrates the player's activity buttons against the current attribute levels and the death flag, and drives the 4-bit `estado` code consumed by `controlador_atributos`. It sits between the button inputs and the attribute controller. Its `fome`/`sono`/`felicidade`/`morreu` inputs are fed back from that controller's outputs.

## Interface
- `MAX_ATTR`, 100: attribute level regarded as full. An activity ends when its attribute is ≥ this value.
- `TIMEOUT_CYC`, 1000: maximum activity duration in clock cycles (10 s at the 100 Hz system clock).
- `clk`  in  1  system clock, 100 Hz.
- `rst`  in  1  reset; asynchronous, active-high.
- `btn_dormir`, `btn_comer`, `btn_aula`, `btn_cancelar`  in  1 each  synchronous active-high button levels, already debounced.
- `fome`, `sono`, `felicidade`  in  8 each  current attribute levels, unsigned.
- `morreu`  in  1  death flag from the attribute controller.
- `estado`  out  4  current state code, registered.
- `rejeitado`  out  1  one-cycle pulse when a request edge is refused.

## Operation
- **State codes:**
  - IDLE 0000
  - DORMINDO 0001
  - COMENDO 0010
  - DANDO_AULA 0100
  - MORTO 1000
- **Activity-to-attribute map:**
  - DORMINDO→`sono`
  - COMENDO→`fome`
  - DANDO_AULA→`felicidade`
- **Requests:** only rising edges count. Each button is registered once, and an edge is current level high while the previous sample is low. Held buttons generate no further requests.
- **From IDLE:**
  - One request edge: enter that activity unless its attribute is ≥ `MAX_ATTR`. In that case stay IDLE and pulse `rejeitado`.
  - Simultaneous edges: fixed priority COMENDO > DORMINDO > DANDO_AULA.
  - If the winner is refused because its attribute is full, the next eligible requester is granted. `rejeitado` pulses only if no requester is granted.
  - `btn_cancelar` in IDLE has no effect.
- **From any activity, return to IDLE when any of these holds:**
  - The mapped attribute is ≥ `MAX_ATTR`.
  - A `btn_cancelar` edge occurs.
  - The cycle counter reaches `TIMEOUT_CYC-1`.
- **Requests during an activity:** any activity-button edge (including the same activity) is refused, pulsing `rejeitado`. The state is unchanged.
- **Death:** `morreu` high in any state forces MORTO at the next edge. This overrides every request, cancel and timeout in the same cycle. MORTO is terminal: only `rst` leaves it, and requests in MORTO are silently ignored with no `rejeitado` pulse.
- **Cycle counter:** 16-bit, cleared on every entry to an activity, increments each cycle in an activity, held at 0 in IDLE/MORTO. Comparisons are unsigned and compare against `TIMEOUT_CYC-1`.

## Timing
- **Reset values:**
  - `estado`=0000
  - `rejeitado`=0
  - counter=0
  - edge registers=0, so a button held through reset release produces an edge on the first sample.
- **Latency:** `estado` and `rejeitado` change on the same clock edge at which the triggering input is first sampled, i.e. 1-cycle registered latency. `rejeitado` is high for exactly one cycle per refused edge.
- **Timeout:** with no other exit, an activity entered at edge k returns to IDLE at edge k+`TIMEOUT_CYC`. `estado` is non-IDLE for exactly `TIMEOUT_CYC` cycles.
- **Same-cycle exit and request:** if an exit condition and a new request edge coincide, go to IDLE and refuse the request. No direct activity-to-activity transition exists.
- **Reset mid-activity:** `rst` asserted mid-activity forces IDLE immediately (asynchronously). Counter and edge registers clear.

## Structure
- Shared header `tamagotchi_defs.vh` holds the five state-code localparams. `controlador_atributos` and the display logic include the same header.
- One natural sub-module, `detector_borda`: clk/rst/in → `pulso`, rising-edge detection. Instantiate it four times.
- The FSM, priority grant and counter live in `controlador_estados` itself.

## Test plan
1. Reset, `fome`=40, `btn_comer` edge → `estado`=0010 next edge. Ramp `fome` to 100 → `estado`=0000 on the edge sampling 100.
2. `sono`=100, `btn_dormir` edge → `estado` stays 0000, `rejeitado` high 1 cycle.
3. `btn_comer` and `btn_dormir` edges same cycle, `fome`=100, `sono`=20 → `estado`=0001, `rejeitado`=0.
4. DANDO_AULA with `felicidade` held at 50 → returns to 0000 after exactly 1000 cycles. Then in DANDO_AULA, a `btn_comer` edge → `rejeitado` pulse and state unchanged, and a `btn_cancelar` edge → 0000.
5. In COMENDO, assert `morreu` together with a `btn_cancelar` edge → `estado`=1000. Further button edges → no change, `rejeitado`=0.
6. `rst` asserted mid-DORMINDO between clock edges → `estado`=0000 before the next edge. A `btn_dormir` held high across reset release → enters 0001 on the first edge.

Source files
------------

// File: rtl/controlador_estados_pkg.sv
// controlador_estados_pkg: state codes shared by the pet sequencer and its neighbours
package controlador_estados_pkg;
  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;
endpackage

// File: rtl/controlador_estados_if.sv
// controlador_estados_if: buttons, attribute feedback and state outputs of the sequencer
interface controlador_estados_if;
  logic btn_dormir, btn_comer, btn_aula, btn_cancelar;
  logic [7:0] fome, sono, felicidade;
  logic morreu;
  logic [3:0] estado;
  logic rejeitado;
  modport master (output btn_dormir, btn_comer, btn_aula, btn_cancelar, fome, sono, felicidade, morreu,
                  input estado, rejeitado);
  modport slave (input btn_dormir, btn_comer, btn_aula, btn_cancelar, fome, sono, felicidade, morreu,
                 output estado, rejeitado);
endinterface

// File: rtl/controlador_estados_detector_borda.sv
// detector_borda: rising-edge pulse; previous sample clears to 0 so a level held through reset counts
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulso
);
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= in;
  assign pulso = in & ~prev;
endmodule

// File: rtl/controlador_estados.sv
// controlador_estados: arbitrates activity button edges against attribute levels and death
module controlador_estados
  import controlador_estados_pkg::*;
#(
  parameter logic [7:0]  MAX_ATTR    = 8'd100,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input logic clk,
  input logic rst,
  controlador_estados_if.slave bus
);
  logic e_dormir, e_comer, e_aula, e_cancelar, any_req;
  logic [7:0] attr;
  estado_t st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic rej_q, rej_d;
  detector_borda u_dormir   (.clk(clk), .rst(rst), .in(bus.btn_dormir),   .pulso(e_dormir));
  detector_borda u_comer    (.clk(clk), .rst(rst), .in(bus.btn_comer),    .pulso(e_comer));
  detector_borda u_aula     (.clk(clk), .rst(rst), .in(bus.btn_aula),     .pulso(e_aula));
  detector_borda u_cancelar (.clk(clk), .rst(rst), .in(bus.btn_cancelar), .pulso(e_cancelar));
  always_comb begin
    attr = st_q == DORMINDO ? bus.sono : st_q == COMENDO ? bus.fome : bus.felicidade;
    any_req = e_dormir | e_comer | e_aula;
    st_d = st_q;
    cnt_d = '0;
    rej_d = 1'b0;
    if (bus.morreu || st_q == MORTO) st_d = MORTO;
    else if (st_q == IDLE) begin
      // a full winner falls through to the next requester in priority order
      st_d = (e_comer && bus.fome < MAX_ATTR)        ? COMENDO :
             (e_dormir && bus.sono < MAX_ATTR)       ? DORMINDO :
             (e_aula && bus.felicidade < MAX_ATTR)   ? DANDO_AULA : IDLE;
      rej_d = any_req && st_d == IDLE;
    end else begin
      rej_d = any_req;
      st_d = (attr >= MAX_ATTR || e_cancelar || cnt_q == TIMEOUT_CYC - 16'd1) ? IDLE : st_q;
      cnt_d = st_d == IDLE ? '0 : cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      rej_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      rej_q <= rej_d;
    end
  assign bus.estado = st_q;
  assign bus.rejeitado = rej_q;
endmodule

// File: tb/tb_controlador_estados.sv
// tb_controlador_estados: vector table, hand sequences and random stimulus against a reference model
module tb_controlador_estados;
  import controlador_estados_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  controlador_estados_if bus ();
  controlador_estados dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // model: bits of b are {cancelar, aula, comer, dormir}
  logic [3:0] m_st, m_prev;
  logic m_rej;
  int cyc = 0, t_entry = 0;
  localparam logic [3:0] PRIO_ST [3] = '{4'b0010, 4'b0001, 4'b0100};
  localparam int PRIO_BTN [3] = '{1, 0, 2};

  typedef struct {
    logic [3:0] b;
    logic [7:0] f, s, h;
    logic m;
    logic [3:0] st;
    logic rej;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [7:0] attr_of(input logic [3:0] st, input logic [7:0] f, s, h);
    return st == 4'b0001 ? s : st == 4'b0010 ? f : h;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] b, input logic [7:0] f, s, h, input logic m);
    logic [3:0] e;
    bit granted;
    e = b & ~m_prev;
    m_prev = b;
    cyc++;
    m_rej = 1'b0;
    granted = 0;
    if (m_st == 4'b1000) m_st = 4'b1000;
    else if (m) m_st = 4'b1000;
    else if (m_st == 4'b0000) begin
      for (int k = 0; k < 3; k++)
        if (!granted && e[PRIO_BTN[k]] && attr_of(PRIO_ST[k], f, s, h) < 8'd100) begin
          granted = 1;
          m_st = PRIO_ST[k];
          t_entry = cyc;
        end
      m_rej = (|e[2:0]) && !granted;
    end else begin
      m_rej = |e[2:0];
      if (attr_of(m_st, f, s, h) >= 8'd100 || e[3] || cyc - t_entry >= 1000) m_st = 4'b0000;
    end
  endtask

  task automatic step(input logic [3:0] b, input logic [7:0] f, s, h, input logic m, input string name);
    bus.btn_dormir = b[0];
    bus.btn_comer = b[1];
    bus.btn_aula = b[2];
    bus.btn_cancelar = b[3];
    bus.fome = f;
    bus.sono = s;
    bus.felicidade = h;
    bus.morreu = m;
    model_step(b, f, s, h, m);
    @(posedge clk);
    #1;
    check({name, "_model_estado"}, bus.estado, m_st);
    check({name, "_model_rej"}, {3'b0, bus.rejeitado}, {3'b0, m_rej});
  endtask

  task automatic reset_dut(input string name);
    rst = 1'b1;
    #1;
    m_st = 4'b0000;
    m_prev = 4'b0000;
    m_rej = 1'b0;
    check({name, "_rst_estado"}, bus.estado, 4'b0000);
    check({name, "_rst_rej"}, {3'b0, bus.rejeitado}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.btn_dormir = 0; bus.btn_comer = 0; bus.btn_aula = 0; bus.btn_cancelar = 0;
    bus.fome = 0; bus.sono = 0; bus.felicidade = 0; bus.morreu = 0;
    m_st = 0; m_prev = 0; m_rej = 0;
    reset_dut("init");
    tbl.push_back('{4'b0000, 8'd40,  8'd20,  8'd50,  1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0010, 8'd40,  8'd20,  8'd50,  1'b0, 4'b0010, 1'b0});
    tbl.push_back('{4'b0010, 8'd90,  8'd20,  8'd50,  1'b0, 4'b0010, 1'b0});
    tbl.push_back('{4'b0000, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0001, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0000, 1'b1});
    tbl.push_back('{4'b0000, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0011, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0001, 1'b0});
    tbl.push_back('{4'b0000, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0001, 1'b0});
    tbl.push_back('{4'b0010, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0001, 1'b1});
    tbl.push_back('{4'b0000, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0001, 1'b0});
    tbl.push_back('{4'b1000, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b1000, 8'd100, 8'd20,  8'd50,  1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 8'd100, 8'd100, 8'd100, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0111, 8'd100, 8'd100, 8'd100, 1'b0, 4'b0000, 1'b1});
    tbl.push_back('{4'b0000, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0111, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0100, 1'b0});
    tbl.push_back('{4'b0000, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0100, 1'b0});
    tbl.push_back('{4'b0001, 8'd100, 8'd100, 8'd100, 1'b0, 4'b0000, 1'b1});
    tbl.push_back('{4'b0100, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0100, 1'b0});
    tbl.push_back('{4'b0000, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0100, 1'b0});
    tbl.push_back('{4'b1000, 8'd100, 8'd100, 8'd50,  1'b0, 4'b0000, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].f, tbl[i].s, tbl[i].h, tbl[i].m, "tbl");
      check($sformatf("tbl%0d_estado", i), bus.estado, tbl[i].st);
      check($sformatf("tbl%0d_rej", i), {3'b0, bus.rejeitado}, {3'b0, tbl[i].rej});
    end

    // timeout: non-IDLE for exactly 1000 cycles
    step(4'b0000, 8'd50, 8'd50, 8'd50, 1'b0, "to_pre");
    step(4'b0100, 8'd50, 8'd50, 8'd50, 1'b0, "to_enter");
    check("to_enter", bus.estado, 4'b0100);
    for (int i = 1; i < 1000; i++) step(4'b0000, 8'd50, 8'd50, 8'd50, 1'b0, "to_run");
    check("to_last_cycle", bus.estado, 4'b0100);
    step(4'b0000, 8'd50, 8'd50, 8'd50, 1'b0, "to_exit");
    check("to_exit", bus.estado, 4'b0000);
    step(4'b0100, 8'd50, 8'd50, 8'd50, 1'b0, "aula2");
    step(4'b0010, 8'd50, 8'd50, 8'd50, 1'b0, "aula_req");
    check("aula_req_estado", bus.estado, 4'b0100);
    check("aula_req_rej", {3'b0, bus.rejeitado}, 4'b0001);
    step(4'b0000, 8'd50, 8'd50, 8'd50, 1'b0, "aula_idle");
    check("aula_rej_one_cycle", {3'b0, bus.rejeitado}, 4'b0000);
    step(4'b1000, 8'd50, 8'd50, 8'd50, 1'b0, "aula_cancel");
    check("aula_cancel", bus.estado, 4'b0000);

    // async reset mid-DORMINDO, button held through release
    step(4'b0000, 8'd50, 8'd20, 8'd50, 1'b0, "rs_pre");
    step(4'b0001, 8'd50, 8'd20, 8'd50, 1'b0, "rs_enter");
    check("rs_enter", bus.estado, 4'b0001);
    #2;
    reset_dut("rs_mid");
    step(4'b0001, 8'd50, 8'd20, 8'd50, 1'b0, "rs_held");
    check("rs_held_enter", bus.estado, 4'b0001);

    for (int i = 0; i < 4000; i++) begin
      logic [3:0] b;
      logic [7:0] a [3];
      for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 3; j++) a[j] = ($urandom_range(0, 1) == 0) ? 8'(90 + $urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      if (m_st == 4'b1000 && $urandom_range(0, 9) == 0) reset_dut("rnd");
      step(b, a[0], a[1], a[2], $urandom_range(0, 299) == 0, "rnd");
    end

    // death overrides cancel and is terminal
    reset_dut("dead");
    step(4'b0010, 8'd40, 8'd50, 8'd50, 1'b0, "dead_enter");
    check("dead_enter", bus.estado, 4'b0010);
    step(4'b0000, 8'd40, 8'd50, 8'd50, 1'b0, "dead_hold");
    step(4'b1000, 8'd40, 8'd50, 8'd50, 1'b1, "dead_hit");
    check("dead_estado", bus.estado, 4'b1000);
    check("dead_rej", {3'b0, bus.rejeitado}, 4'b0000);
    step(4'b0111, 8'd40, 8'd50, 8'd50, 1'b0, "dead_req");
    check("dead_req_estado", bus.estado, 4'b1000);
    check("dead_req_rej", {3'b0, bus.rejeitado}, 4'b0000);
    step(4'b0000, 8'd40, 8'd50, 8'd50, 1'b0, "dead_idle");
    step(4'b1000, 8'd40, 8'd50, 8'd50, 1'b0, "dead_cancel");
    check("dead_cancel", bus.estado, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
